// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: round-robin arbiter sequencing a shared iterative multiplier, with a watchdog abort
module mul_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [63:0]             resp_product,
  output logic                    resp_err,
  output logic                    busy,
  output logic                    mul_rst,
  output logic [31:0]             mul_multiplier,
  output logic [31:0]             mul_multiplicand,
  input  logic                    mul_flag,
  input  logic [63:0]             mul_product
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;
  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_q, rr_d, id_q, id_d, g;
  logic [ID_W:0]   sum;
  logic            found;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [63:0]     prod_q, prod_d;
  logic            err_q, err_d;
  // descending scan so the last hit is the first valid requester at or after rr_q
  always_comb begin
    found = 1'b0;
    g     = '0;
    sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_q} + (ID_W + 1)'(k);
      sum = (sum >= (ID_W + 1)'(NUM_REQ)) ? sum - (ID_W + 1)'(NUM_REQ) : sum;
      if (req_valid[sum[ID_W-1:0]]) begin
        found = 1'b1;
        g     = sum[ID_W-1:0];
      end
    end
  end
  assign req_ready        = (state_q == IDLE && found && !rst) ? NUM_REQ'(1) << g : '0;
  assign busy             = state_q != IDLE;
  assign mul_rst          = state_q != RUN;
  assign resp_valid       = state_q == DONE;
  assign resp_id          = id_q;
  assign resp_product     = prod_q;
  assign resp_err         = err_q;
  assign mul_multiplier   = a_q;
  assign mul_multiplicand = b_q;
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (found) begin
        state_d = LOAD;
        id_d    = g;
        a_d     = req_a[32*g +: 32];
        b_d     = req_b[32*g +: 32];
        rr_d    = (g == ID_W'(NUM_REQ - 1)) ? '0 : g + ID_W'(1);
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (mul_flag) begin
          prod_d  = mul_product;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = resp_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb_mul_share_ctrl: randomized and directed bench with a timestamp-based reference model and a multiplier stub
module tb_mul_share_ctrl;
  localparam int N = 4, IW = 2, TO = 64;
  logic clk = 0, rst = 1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [32*N-1:0] req_a = '0, req_b = '0;
  logic resp_valid, resp_ready = 0;
  logic [IW-1:0] resp_id;
  logic [63:0] resp_product;
  logic resp_err, busy, mul_rst;
  logic [31:0] mul_multiplier, mul_multiplicand;
  logic mul_flag = 0;
  logic [63:0] mul_product = '0;
  int tests = 0, fails = 0;
  int cfg_lat = 4, op_lat = 4;
  bit cfg_hang = 0, op_hang = 0, chk_en = 0;

  always #5 clk = ~clk;

  mul_share_ctrl #(.NUM_REQ(N), .ID_W(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_product(resp_product), .resp_err(resp_err), .busy(busy),
    .mul_rst(mul_rst), .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
    .mul_flag(mul_flag), .mul_product(mul_product));

  function automatic logic [63:0] smul(logic [31:0] x, logic [31:0] y);
    logic signed [63:0] ex, ey;
    ex = {{32{x[31]}}, x};
    ey = {{32{y[31]}}, y};
    return ex * ey;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // multiplier stub: loads while held, raises flag op_lat run cycles after release
  logic [31:0] sa = '0, sb = '0;
  int run_cnt = 0;
  always @(posedge clk) begin
    if (mul_rst) begin
      sa <= mul_multiplier;
      sb <= mul_multiplicand;
      run_cnt <= 0;
      mul_flag <= 1'b0;
    end else begin
      run_cnt <= run_cnt + 1;
      if (!op_hang && run_cnt + 1 == op_lat) begin
        mul_flag <= 1'b1;
        mul_product <= smul(sa, sb);
      end
    end
  end

  // reference model: m_t counts cycles since acceptance; 1 = load, then m_nrun run cycles, then response
  bit m_busy = 0, m_err = 0;
  int m_t = 0, m_nrun = 0, m_rr = 0;
  logic [IW-1:0] m_id = '0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [63:0] m_prod = '0;
  always @(negedge clk) begin : model
    logic [N-1:0] er;
    int g;
    bit run, done;
    if (chk_en) begin
      er = '0;
      g = -1;
      if (!m_busy && !rst)
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
      if (g >= 0) er[g] = 1'b1;
      run  = m_busy && m_t >= 2 && m_t < 2 + m_nrun;
      done = m_busy && m_t >= 2 + m_nrun;
      check("busy", busy, m_busy);
      check("req_ready", req_ready, er);
      check("mul_rst", mul_rst, !run);
      check("resp_valid", resp_valid, done);
      check("mul_multiplier", mul_multiplier, m_a);
      check("mul_multiplicand", mul_multiplicand, m_b);
      if (done) begin
        check("resp_id", resp_id, m_id);
        check("resp_product", resp_product, m_prod);
        check("resp_err", resp_err, m_err);
      end
      if (rst) begin
        m_busy = 0; m_rr = 0; m_a = '0; m_b = '0; m_t = 0;
      end else if (!m_busy) begin
        if (g >= 0) begin
          m_busy = 1; m_t = 1;
          m_id = g[IW-1:0];
          m_a = req_a[32*g +: 32];
          m_b = req_b[32*g +: 32];
          m_rr = (g + 1) % N;
          m_err = cfg_hang || cfg_lat >= TO;
          m_nrun = m_err ? TO : cfg_lat + 1;
          m_prod = m_err ? 64'd0 : smul(m_a, m_b);
          op_lat = cfg_lat;
          op_hang = cfg_hang;
        end
      end else if (done && resp_ready) m_busy = 0;
      else m_t++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic [31:0] a, logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_grant(int i, bit keep);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        cyc();
        if (!keep) req_valid[i] = 1'b0;
        return;
      end
    end
    tests++; fails++;
    $display("FAIL grant%0d: no req_ready within 300 cycles, required a grant", i);
    cyc();
  endtask

  task automatic wait_resp(int id, logic [63:0] p, bit e);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin
        check("lit_id", resp_id, id);
        check("lit_product", resp_product, p);
        check("lit_err", resp_err, e);
        cyc();
        return;
      end
    end
    tests++; fails++;
    $display("FAIL resp%0d: no response within 300 cycles, required one", id);
    cyc();
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hffff_ffff;
      2: return 32'h0;
      3: return 32'h7fff_ffff;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] gr;
    int n, runs, r;
    repeat (3) cyc();
    chk_en = 1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mul_rst", mul_rst, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_product", resp_product, 0);
    cyc();
    rst = 0;
    resp_ready = 1;
    set_req(0, 5, 7);
    wait_grant(0, 0);
    wait_resp(0, 35, 0);
    @(negedge clk);
    check("idle_after_hs", busy, 0);
    cyc();
    set_req(1, -32'sd5, -32'sd11);
    set_req(3, 32'h7ff7a099, 32'hf0f7a099);
    wait_grant(1, 0);
    wait_resp(1, 55, 0);
    wait_grant(3, 0);
    wait_resp(3, 64'hF87C4E29A2FD9B71, 0);
    for (int i = 0; i < N; i++) set_req(i, i + 1, 10);
    for (int k = 0; k < 8; k++) begin
      wait_grant(k % N, k < 7);
      if (k == 7) req_valid = '0;
      wait_resp(k % N, 10 * (k % N + 1), 0);
    end
    resp_ready = 0;
    set_req(0, -32'sd4, 200);
    wait_grant(0, 0);
    set_req(1, 3, 3);
    for (n = 0; n < 100 && !resp_valid; n++) @(negedge clk);
    cyc();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("stall_valid", resp_valid, 1);
      check("stall_id", resp_id, 0);
      check("stall_product", resp_product, -64'd800);
      check("stall_ready", req_ready, 0);
    end
    cyc();
    resp_ready = 1;
    wait_resp(0, -64'd800, 0);
    @(negedge clk);
    check("post_hs_busy", busy, 0);
    check("post_hs_grant", req_ready, 4'b0010);
    cyc();
    req_valid[1] = 0;
    wait_resp(1, 9, 0);
    resp_ready = 0;
    cfg_hang = 1;
    set_req(2, 9, 9);
    wait_grant(2, 0);
    runs = 0;
    for (n = 1; n < 200; n++) begin
      @(negedge clk);
      if (resp_valid) break;
      runs += !mul_rst;
    end
    check("timeout_latency", n, 66);
    check("timeout_run_cycles", runs, 64);
    check("timeout_err", resp_err, 1);
    check("timeout_product", resp_product, 0);
    cyc();
    cfg_hang = 0;
    resp_ready = 1;
    wait_resp(2, 0, 1);
    set_req(3, 6, 7);
    wait_grant(3, 0);
    wait_resp(3, 42, 0);
    cfg_lat = 63;
    set_req(0, -32'sd3, 3);
    wait_grant(0, 0);
    wait_resp(0, -64'd9, 0);
    cfg_lat = 64;
    set_req(1, 5, 5);
    wait_grant(1, 0);
    wait_resp(1, 0, 1);
    cfg_lat = 30;
    set_req(2, 123, 456);
    wait_grant(2, 0);
    repeat (5) cyc();
    rst = 1;
    cyc();
    rst = 0;
    @(negedge clk);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_mul_rst", mul_rst, 1);
    check("midrun_rst_valid", resp_valid, 0);
    check("midrun_rst_id", resp_id, 0);
    check("midrun_rst_err", resp_err, 0);
    check("midrun_rst_product", resp_product, 0);
    check("midrun_rst_mul_a", mul_multiplier, 0);
    cyc();
    repeat (40) cyc();
    cfg_lat = 4;
    set_req(1, 2, 2);
    set_req(3, 2, 3);
    @(negedge clk);
    check("rr_after_rst", req_ready, 4'b0010);
    cyc();
    req_valid[1] = 0;
    wait_resp(1, 4, 0);
    wait_grant(3, 0);
    wait_resp(3, 6, 0);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      gr = req_ready;
      cyc();
      rst = $urandom_range(0, 599) == 0;
      resp_ready = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 99);
      cfg_hang = r < 3;
      cfg_lat = r < 6 ? 63 : r < 9 ? 64 : $urandom_range(1, 20);
      for (int i = 0; i < N; i++) begin
        if (gr[i] || !req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) set_req(i, rnd(), rnd());
          else req_valid[i] = 0;
        end else if ($urandom_range(0, 29) == 0) req_valid[i] = 0;
      end
    end
    rst = 0;
    req_valid = '0;
    resp_ready = 1;
    cfg_hang = 0;
    cfg_lat = 4;
    repeat (200) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
